// File: rtl/ethernet_packet_framer.sv
// rtl/ethernet_packet_framer.sv - 1000BASE-T transmit framer driving RGMII DDR output nibble pairs
module ethernet_packet_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int INTER_FRAME_GAP = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] transmit_data,
  input  logic       transmit_data_enable,
  output logic       transmit_data_ready,
  output logic [3:0] ddr_data_rising,
  output logic [3:0] ddr_data_falling,
  output logic       ddr_txctl_rising,
  output logic       ddr_txctl_falling,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DROP, GAP} state_t;

  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME_BYTES);
  localparam logic [15:0] GAP_LAST = 16'((INTER_FRAME_GAP > 0) ? INTER_FRAME_GAP - 1 : 0);

  state_t      state, state_next;
  logic [31:0] crc, crc_next;
  logic [10:0] byte_count, byte_count_next, byte_count_inc;
  logic [11:0] count_plus_one;
  logic [15:0] cnt, cnt_next;
  logic [31:0] fcs_word;
  logic [7:0]  line_byte;
  logic        line_en, line_er, done_next, underrun_next;

  // Reflected IEEE 802.3 CRC-32, one byte per clock, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (32'hEDB88320 & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  assign transmit_data_ready = (state == DATA) || (state == DROP);
  assign byte_count_inc      = (byte_count == 11'h7FF) ? byte_count : byte_count + 11'd1;
  assign count_plus_one      = {1'b0, byte_count} + 12'd1;
  assign fcs_word            = ~crc;

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    crc_next        = crc;
    byte_count_next = byte_count;
    line_byte       = 8'h00;
    line_en         = 1'b0;
    line_er         = 1'b0;
    done_next       = 1'b0;
    underrun_next   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && transmit_data_enable) begin
          state_next = PREAMBLE;
          cnt_next   = 16'd0;
        end
      end
      PREAMBLE: begin
        line_byte = 8'h55;
        line_en   = 1'b1;
        cnt_next  = cnt + 16'd1;
        if (cnt == 16'd6) begin
          state_next = SFD;
          cnt_next   = 16'd0;
        end
      end
      SFD: begin
        line_byte       = 8'hD5;
        line_en         = 1'b1;
        crc_next        = 32'hFFFFFFFF;
        byte_count_next = 11'd0;
        state_next      = DATA;
      end
      DATA: begin
        if (transmit_data_enable) begin
          line_byte       = transmit_data[7:0];
          line_en         = 1'b1;
          crc_next        = crc_byte(crc, transmit_data[7:0]);
          byte_count_next = byte_count_inc;
          cnt_next        = 16'd0;
          if (transmit_data[8]) begin
            state_next = (count_plus_one < MIN_LEN) ? PAD : FCS;
          end
        end else begin
          // Starved mid-frame: poison the frame on the wire with one error byte.
          line_en       = 1'b1;
          line_er       = 1'b1;
          underrun_next = 1'b1;
          state_next    = DROP;
        end
      end
      PAD: begin
        line_en         = 1'b1;
        crc_next        = crc_byte(crc, 8'h00);
        byte_count_next = byte_count_inc;
        if (count_plus_one >= MIN_LEN) begin
          state_next = FCS;
          cnt_next   = 16'd0;
        end
      end
      FCS: begin
        line_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
        line_en   = 1'b1;
        cnt_next  = cnt + 16'd1;
        if (cnt[1:0] == 2'd3) begin
          done_next  = 1'b1;
          state_next = GAP;
          cnt_next   = 16'd0;
        end
      end
      DROP: begin
        if (transmit_data_enable && transmit_data[8]) begin
          state_next = GAP;
          cnt_next   = 16'd0;
        end
      end
      GAP: begin
        cnt_next = cnt + 16'd1;
        // The last gap cycle stands in for IDLE so back-to-back frames get exactly the gap.
        if (cnt >= GAP_LAST) begin
          cnt_next   = 16'd0;
          state_next = (enable && transmit_data_enable) ? PREAMBLE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      crc               <= 32'hFFFFFFFF;
      byte_count        <= 11'd0;
      cnt               <= 16'd0;
      ddr_data_rising   <= 4'd0;
      ddr_data_falling  <= 4'd0;
      ddr_txctl_rising  <= 1'b0;
      ddr_txctl_falling <= 1'b0;
      frame_done        <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      state             <= state_next;
      crc               <= crc_next;
      byte_count        <= byte_count_next;
      cnt               <= cnt_next;
      ddr_data_rising   <= line_byte[3:0];
      ddr_data_falling  <= line_byte[7:4];
      ddr_txctl_rising  <= line_en;
      ddr_txctl_falling <= line_en ^ line_er;
      frame_done        <= done_next;
      underrun          <= underrun_next;
    end
  end

endmodule

// File: tb/tb_ethernet_packet_framer.sv
// tb/tb_ethernet_packet_framer.sv - directed bench for ethernet_packet_framer
module tb_ethernet_packet_framer;

  logic       clock = 1'b0;
  logic       reset, en0, en1, tde, sel;
  logic [8:0] td;
  logic [3:0] r0, f0, r1, f1;
  logic       cr0, cf0, fd0, ur0, rdy0, cr1, cf1, fd1, ur1, rdy1;
  logic [3:0] s_r, s_f;
  logic       s_cr, s_cf, s_fd, s_ur, s_rdy;

  always #4 clock = ~clock;

  ethernet_packet_framer #(.MIN_FRAME_BYTES(0), .INTER_FRAME_GAP(12)) dut0 (
    .clock(clock), .reset(reset), .enable(en0), .transmit_data(td),
    .transmit_data_enable(tde), .transmit_data_ready(rdy0),
    .ddr_data_rising(r0), .ddr_data_falling(f0),
    .ddr_txctl_rising(cr0), .ddr_txctl_falling(cf0),
    .frame_done(fd0), .underrun(ur0));

  ethernet_packet_framer dut1 (
    .clock(clock), .reset(reset), .enable(en1), .transmit_data(td),
    .transmit_data_enable(tde), .transmit_data_ready(rdy1),
    .ddr_data_rising(r1), .ddr_data_falling(f1),
    .ddr_txctl_rising(cr1), .ddr_txctl_falling(cf1),
    .frame_done(fd1), .underrun(ur1));

  assign s_r   = sel ? r1 : r0;
  assign s_f   = sel ? f1 : f0;
  assign s_cr  = sel ? cr1 : cr0;
  assign s_cf  = sel ? cf1 : cf0;
  assign s_fd  = sel ? fd1 : fd0;
  assign s_ur  = sel ? ur1 : ur0;
  assign s_rdy = sel ? rdy1 : rdy0;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  src[$];
  logic [7:0]  exp_q[$];
  logic [12:0] lg[$];   // {rdy, underrun, frame_done, txctl_r, txctl_f, byte}
  int          src_idx, hole_at, s, last, s2;
  bit          hole_used;
  logic [12:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [12:0] ent(input int i);
    if (i >= 0 && i < lg.size()) return lg[i];
    return 'x;
  endfunction

  function automatic int find_start();
    for (int i = 0; i < lg.size(); i++) if (lg[i][9]) return i;
    return lg.size();
  endfunction

  function automatic int count_bit(input int b);
    int n = 0;
    for (int i = 0; i < lg.size(); i++) if (lg[i][b]) n++;
    return n;
  endfunction

  task automatic new_test(input logic which);
    sel = which;
    lg.delete(); src.delete(); exp_q.delete();
    src_idx = 0; hole_at = -1; hole_used = 0;
  endtask

  task automatic add_byte(input logic [7:0] b, input logic is_last);
    src.push_back({is_last, b});
    exp_q.push_back(b);
  endtask

  task automatic add_pad(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
  endtask

  task automatic cycle();
    bit acc;
    if (src_idx < src.size()) begin
      if (src_idx == hole_at && !hole_used && s_rdy) begin
        tde = 1'b0; hole_used = 1'b1;
      end else begin
        tde = 1'b1; td = src[src_idx];
      end
    end else begin
      tde = 1'b0; td = 9'h000;
    end
    acc = tde && s_rdy;
    @(posedge clock);
    @(negedge clock);
    if (acc) src_idx++;
    lg.push_back({s_rdy, s_ur, s_fd, s_cr, s_cf, s_f, s_r});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic check_line(input string tag, input int i, input logic [7:0] b);
    logic [12:0] x;
    x = ent(i);
    check(tag, {22'h0, x[9:0]}, {22'h0, 2'b11, b});
  endtask

  task automatic check_idle(input string tag, input int i, input int n);
    logic [12:0] x;
    for (int k = 0; k < n; k++) begin
      x = ent(i + k);
      check(tag, {22'h0, x[9:0]}, 32'h0);
    end
  endtask

  task automatic check_head(input string tag, input int st, input int n);
    for (int i = 0; i < 7; i++) check_line({tag, "_pre"}, st + i, 8'h55);
    check_line({tag, "_sfd"}, st + 7, 8'hD5);
    for (int i = 0; i < n; i++) check_line({tag, "_data"}, st + 8 + i, exp_q[i]);
  endtask

  task automatic check_frame(input string tag, input int st, input bit ovr,
                             input logic [31:0] ovr_fcs, output int fcs_last);
    logic [31:0] c;
    logic [12:0] x;
    int n;
    n = exp_q.size();
    check_head(tag, st, n);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_model(c, exp_q[i]);
    c = ovr ? ovr_fcs : ~c;
    for (int i = 0; i < 4; i++) check_line({tag, "_fcs"}, st + 8 + n + i, c[8*i +: 8]);
    fcs_last = st + 8 + n + 3;
    x = ent(fcs_last);
    check({tag, "_done_pulse"}, {31'h0, x[10]}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; en0 = 1'b0; en1 = 1'b0; tde = 1'b0; td = 9'h000; sel = 1'b1;
    hole_at = -1; src_idx = 0; hole_used = 0;
    repeat (2) @(negedge clock);
    check("reset_dut0", {19'h0, r0, f0, cr0, cf0, fd0, ur0, rdy0}, 32'h0);
    check("reset_dut1", {19'h0, r1, f1, cr1, cf1, fd1, ur1, rdy1}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // "123456789" with no padding: known CRC 0xCBF43926.
    new_test(1'b0);
    en0 = 1'b1;
    for (int i = 1; i <= 9; i++) add_byte(8'(8'h30 + i), i == 9);
    run(50);
    en0 = 1'b0;
    s = find_start();
    check("t1_start", s, 1);
    check_frame("t1", s, 1'b1, 32'hCBF43926, last);
    check_idle("t1_gap", last + 1, 12);
    check("t1_done_count", count_bit(10), 1);
    check("t1_ready_cycles", count_bit(12), 9);
    check("t1_consumed", src_idx, 9);

    // 14-byte frame padded to 60.
    new_test(1'b1);
    en1 = 1'b1;
    for (int i = 0; i < 14; i++) add_byte(8'(8'hA0 + i), i == 13);
    add_pad(46);
    run(100);
    s = find_start();
    check("t2_start", s, 1);
    check_frame("t2", s, 1'b0, 32'h0, last);
    check("t2_fcs_index", last, 72);
    check_idle("t2_gap", last + 1, 12);
    check("t2_done_count", count_bit(10), 1);

    // 64-byte frame then a queued second frame: exactly 12 idle byte-times between them.
    new_test(1'b1);
    for (int i = 0; i < 64; i++) add_byte(8'(i * 13 + 5), i == 63);
    for (int i = 0; i < 20; i++) src.push_back({i == 19, 8'(i ^ 8'h5A)});
    run(190);
    s = find_start();
    check("t3_start", s, 1);
    check_frame("t3a", s, 1'b0, 32'h0, last);
    check_idle("t3_gap", last + 1, 12);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i ^ 8'h5A));
    add_pad(40);
    s2 = last + 13;
    check_frame("t3b", s2, 1'b0, 32'h0, last);
    check("t3_done_count", count_bit(10), 2);

    // One-cycle starvation after 20 bytes.
    new_test(1'b1);
    for (int i = 0; i < 30; i++) add_byte(8'(8'h10 + i), i == 29);
    hole_at = 20;
    run(80);
    s = find_start();
    check("t4_start", s, 1);
    check_head("t4", s, 20);
    e = ent(s + 28);
    check("t4_error_ctl", {30'h0, e[9:8]}, 32'h2);
    check("t4_underrun_pulse", {31'h0, e[11]}, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      e = ent(s + 28 + k);
      check("t4_drain", {21'h0, e[12], e[9:0]}, 32'h400);
    end
    check_idle("t4_line_idle", s + 29, 40);
    check("t4_consumed", src_idx, 30);
    check("t4_done_count", count_bit(10), 0);
    check("t4_underrun_count", count_bit(11), 1);

    // Reset during preamble, then a clean frame.
    new_test(1'b1);
    for (int i = 0; i < 10; i++) add_byte(8'(8'hC0 + i), i == 9);
    add_pad(50);
    run(4);
    check_line("t5_preamble_active", 3, 8'h55);
    #2 reset = 1'b1;
    #1 check("t5_async_reset", {19'h0, r1, f1, cr1, cf1, fd1, ur1, rdy1}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    lg.delete(); src_idx = 0;
    run(100);
    s = find_start();
    check("t5_start", s, 1);
    check_frame("t5", s, 1'b0, 32'h0, last);
    check("t5_done_count", count_bit(10), 1);

    // enable gating: held off, then raised, then dropped mid-frame.
    new_test(1'b1);
    en1 = 1'b0;
    for (int i = 0; i < 16; i++) add_byte(8'(i * 3), i == 15);
    add_pad(44);
    run(6);
    for (int k = 0; k < 6; k++) begin
      e = ent(k);
      check("t6_hold", {30'h0, e[12], e[9]}, 32'h0);
    end
    check("t6_hold_consumed", src_idx, 0);
    lg.delete();
    en1 = 1'b1;
    run(10);
    en1 = 1'b0;
    run(100);
    s = find_start();
    check("t6_start", s, 1);
    check_frame("t6", s, 1'b0, 32'h0, last);
    check_idle("t6_gap", last + 1, 12);
    check("t6_done_count", count_bit(10), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
